read_organizer_pipe: RTL and testbench
======================================

// Module: read_organizer_pipe
// PURPOSE
//  Parametrised, pipelined successor of the display read organizer. Accepts one pixel
//  request per cycle (sample address + screen line), drives the shared sample-memory
//  address, aligns the per-request channel/pane decision with the memory read latency,
//  and emits one registered trace bit per request. Sits between the VGA timing/address
//  generator and the per-channel capture RAMs.
// PARAMETERS
//  NUM_CH      4     channel count; power of two, 1..8
//  ADDR_W      15    sample address width
//  LINE_W      10    screen line number width
//  SEG_DEPTH   8192  samples per address segment; power of two, <= 2**ADDR_W
//  PANE_LINES  192   screen lines per horizontal pane (band)
//  MEM_LAT     2     capture-RAM read latency in cycles, 1..4
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        asynchronous active-low reset
//  frame_start   in   1        one-cycle pulse at first pixel of a frame
//  mode_in       in   2        requested layout (see MODES)
//  ch_en         in   NUM_CH   per-channel display enable
//  req_valid     in   1        pixel request present this cycle
//  read_address  in   ADDR_W   sample address of the request
//  line_number   in   LINE_W   screen line of the request, 0-based
//  mem_addr      out  ADDR_W   address to capture RAMs (registered)
//  q             in   NUM_CH   RAM read data, valid MEM_LAT cycles after mem_addr
//  Q             out  1        selected trace bit (registered)
//  Q_valid       out  1        Q corresponds to a request
//  mode_active   out  2        layout currently applied
// BEHAVIOUR
//  - Reset: mem_addr=0, Q=0, Q_valid=0, mode_active=0, all pipeline valid bits cleared.
//  - Mode shadowing: mode_active <= mode_in only in the cycle frame_start=1; mode_in
//    changes mid-frame have no effect until the next frame_start.
//  - MODES: m=0,1,2 -> B=2**m panes, clamped to NUM_CH; m=3 reserved -> every request blank.
//    Stage 0 (cycle of req_valid): band = line_number / PANE_LINES (comparator chain,
//    no divider); seg = read_address >> log2(SEG_DEPTH);
//    ch = seg*B + band; blank if band>=B, seg>=NUM_CH/B, or ch_en[ch]=0.
//    Registers mem_addr <= read_address, {valid, ch, blank} enter pipeline.
//  - If req_valid=0, mem_addr holds its value and a bubble (valid=0) enters pipeline.
//  - Pipeline carries {valid, ch, blank} MEM_LAT stages; at final stage
//    Q <= blank ? 0 : q[ch]; Q_valid <= valid. Latency req_valid -> Q_valid = MEM_LAT+1.
//  - No backpressure: one request per cycle sustained, back-to-back, any bubble pattern.
//  - frame_start coincident with req_valid: that request already uses the new mode.
//  - Mode/ch_en are sampled at stage 0 only; in-flight requests keep their decision.
//  - Q=0 whenever Q_valid=0.
//  - rst_n low mid-stream: all in-flight requests dropped, outputs to reset values
//    asynchronously; first Q_valid at earliest MEM_LAT+1 cycles after a post-reset request.
// STRUCTURE
//  - Shared package org_pkg: localparams MODE_SINGLE=0, MODE_DUAL=1, MODE_QUAD=2,
//    MODE_RSVD=3; width helper clog2 used for SEG shift and channel index width.
//  - One sub-module org_delay_line (WIDTH, DEPTH, async active-low reset) carrying
//    {valid, ch, blank}; decode and final mux stay in this module.
// TESTING
//  1 mode 0, ch_en=4'hF, q=4'b0100, req addr 16384 line 10 -> mem_addr=16384 next cycle,
//    Q=1, Q_valid=1 exactly MEM_LAT+1 cycles after request.
//  2 mode 1, q=4'b1000, addr 9000 line 200 -> ch3, Q=1; addr 9000 line 400 -> Q=0 (band 2>=B).
//  3 mode_in=2 changed mid-frame with no frame_start -> mode_active stays 0; after
//    frame_start pulse, line 600 q=4'b1000 -> Q=1 (band 3).
//  4 ch_en=4'b1110, mode 0, addr 100 q=4'hF -> Q=0 with Q_valid=1; mode 3 any req -> Q=0.
//  5 1000 back-to-back random requests with random bubbles vs reference model ->
//    Q/Q_valid sequence matches, no drops or duplicates, for MEM_LAT=1 and 4.
//  6 assert rst_n low with 3 requests in flight -> Q=0, Q_valid=0 immediately;
//    no stale Q_valid after release.

Source files
------------

// File: rtl/read_organizer_pipe_pkg.sv
// org_pkg: layout mode codes and a width helper shared by the read organizer files
package org_pkg;
  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DUAL   = 2'd1;
  localparam logic [1:0] MODE_QUAD   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/read_organizer_pipe_delay.sv
// org_delay_line: DEPTH-stage register chain (clk, rst_n async low, din -> dout after DEPTH cycles)
module org_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/read_organizer_pipe.sv
// read_organizer_pipe: per-request channel/pane decode, capture-RAM address, latency-aligned trace bit Q/Q_valid
module read_organizer_pipe
  import org_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 15,
  parameter int LINE_W     = 10,
  parameter int SEG_DEPTH  = 8192,
  parameter int PANE_LINES = 192,
  parameter int MEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [1:0]        mode_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] read_address,
  input  logic [LINE_W-1:0] line_number,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NUM_CH-1:0] q,
  output logic              Q,
  output logic              Q_valid,
  output logic [1:0]        mode_active
);
  localparam int SEG_SH = clog2(SEG_DEPTH);
  localparam int CH_W   = clog2(NUM_CH) > 0 ? clog2(NUM_CH) : 1;
  localparam int DW     = CH_W + 2;
  logic [1:0]      mode_eff;
  logic [CH_W-1:0] ch0, dch;
  logic            blank0, dv, dblank;
  int              b, band, seg, ch_i;
  assign mode_eff = frame_start ? mode_in : mode_active;
  always_comb begin
    b = mode_eff == MODE_SINGLE ? 1 : mode_eff == MODE_DUAL ? 2 : 4;
    b = b > NUM_CH ? NUM_CH : b;
    band = 0;
    for (int k = 1; k <= 4; k++) band += (int'(line_number) >= k * PANE_LINES) ? 1 : 0;
    seg = int'(read_address >> SEG_SH);
    ch_i = seg * b + band;
    ch0 = ch_i[CH_W-1:0];
    blank0 = mode_eff == MODE_RSVD || band >= b || seg >= NUM_CH / b || !ch_en[ch0];
  end
  org_delay_line #(.WIDTH(DW), .DEPTH(MEM_LAT)) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({req_valid, ch0, blank0}),
    .dout ({dv, dch, dblank})
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_addr    <= '0;
      mode_active <= MODE_SINGLE;
      Q           <= 1'b0;
      Q_valid     <= 1'b0;
    end else begin
      if (frame_start) mode_active <= mode_in;
      if (req_valid) mem_addr <= read_address;
      Q       <= dv & ~dblank & q[dch];
      Q_valid <= dv;
    end
endmodule

// File: tb/tb_read_organizer_pipe.sv
// tb_read_organizer_pipe: scoreboard bench driving MEM_LAT=1 and MEM_LAT=4 instances in parallel
module tb_read_organizer_pipe;
  localparam int NUM_CH = 4, ADDR_W = 15, LINE_W = 10, SEG_DEPTH = 8192, PANE_LINES = 192;
  typedef struct packed {logic q; int cyc;} ent_t;
  logic clk = 0, rst_n = 0, frame_start = 0, req_valid = 0, use_const = 1;
  logic [1:0] mode_in = 0, cur_mode = 0;
  logic [NUM_CH-1:0] ch_en = 4'hF, q_const = 0;
  logic [ADDR_W-1:0] read_address = 0;
  logic [LINE_W-1:0] line_number = 0;
  logic [ADDR_W-1:0] ma [2];
  logic [NUM_CH-1:0] qd [2];
  logic Qo [2], Qv [2];
  logic [1:0] mact [2];
  ent_t sb0[$], sb1[$];
  int cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [3:0] hsh(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
  endfunction
  for (genvar i = 0; i < 2; i++) begin : g
    localparam int L = i == 0 ? 1 : 4;
    localparam int AI = L >= 2 ? L - 2 : 0;
    logic [ADDR_W-1:0] ap [4];
    always @(posedge clk) begin
      ap[0] <= ma[i];
      for (int k = 1; k < 4; k++) ap[k] <= ap[k-1];
    end
    assign qd[i] = use_const ? q_const : hsh(L == 1 ? ma[i] : ap[AI]);
    read_organizer_pipe #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .SEG_DEPTH(SEG_DEPTH),
      .PANE_LINES(PANE_LINES), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mode_in(mode_in), .ch_en(ch_en),
      .req_valid(req_valid), .read_address(read_address), .line_number(line_number),
      .mem_addr(ma[i]), .q(qd[i]), .Q(Qo[i]), .Q_valid(Qv[i]), .mode_active(mact[i]));
  end
  function automatic logic model(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l,
                                 input logic [1:0] m, input logic [NUM_CH-1:0] en);
    int b, band, seg, ch;
    logic [3:0] d;
    if (m == 2'd3) return 1'b0;
    b = 1 << m;
    if (b > NUM_CH) b = NUM_CH;
    band = int'(l) / PANE_LINES;
    seg = int'(a) / SEG_DEPTH;
    if (band >= b || seg >= NUM_CH / b) return 1'b0;
    ch = seg * b + band;
    if (!en[ch]) return 1'b0;
    d = hsh(a);
    return d[ch];
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at cyc %0d", n, act, exp, cyc);
    end
  endtask
  task automatic push(input logic e);
    sb0.push_back('{e, cyc});
    sb1.push_back('{e, cyc});
  endtask
  always @(negedge clk) if (rst_n) begin
    for (int i = 0; i < 2; i++) begin
      int lat;
      ent_t e;
      bit emp;
      lat = i == 0 ? 2 : 5;
      emp = i == 0 ? sb0.size() == 0 : sb1.size() == 0;
      if (!emp) e = i == 0 ? sb0[0] : sb1[0];
      if (Qv[i]) begin
        total++;
        if (emp) begin
          bad++;
          $display("FAIL extra_q_valid inst%0d Q=%b at cyc %0d with nothing expected", i, Qo[i], cyc);
        end else begin
          if (i == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
          if (Qo[i] !== e.q || cyc != e.cyc + lat) begin
            bad++;
            $display("FAIL q_out inst%0d got Q=%b at cyc %0d want Q=%b at cyc %0d", i, Qo[i], cyc, e.q, e.cyc + lat);
          end
        end
      end else begin
        chk($sformatf("q_zero_when_idle inst%0d", i), int'(Qo[i]), 0);
        if (!emp && e.cyc + lat < cyc) begin
          total++;
          bad++;
          $display("FAIL dropped inst%0d request from cyc %0d got Q_valid=0 want Q_valid=1", i, e.cyc);
          if (i == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l, input logic fs,
                       input logic [1:0] m, input logic e);
    req_valid = 1;
    read_address = a;
    line_number = l;
    frame_start = fs;
    mode_in = m;
    push(e);
    tick();
    req_valid = 0;
    frame_start = 0;
    if (fs) cur_mode = m;
    for (int i = 0; i < 2; i++) chk($sformatf("mem_addr inst%0d", i), int'(ma[i]), int'(a));
  endtask
  task automatic drain();
    for (int k = 0; k < 40 && sb0.size() + sb1.size() > 0; k++) tick();
    chk("drain_pending", sb0.size() + sb1.size(), 0);
  endtask
  task automatic chk_mode(input int exp);
    for (int i = 0; i < 2; i++) chk($sformatf("mode_active inst%0d", i), int'(mact[i]), exp);
  endtask
  initial begin
    logic v, fs, e;
    logic [1:0] m;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] l;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_mem_addr inst%0d", i), int'(ma[i]), 0);
      chk($sformatf("reset_q inst%0d", i), int'(Qo[i]), 0);
      chk($sformatf("reset_q_valid inst%0d", i), int'(Qv[i]), 0);
    end
    chk_mode(0);
    rst_n = 1;
    tick();
    q_const = 4'b0100;
    issue(15'd16384, 10'd10, 0, 2'd0, 1);
    drain();
    mode_in = 2'd2;
    repeat (3) tick();
    chk_mode(0);
    q_const = 4'b1000;
    issue(15'd9000, 10'd200, 1, 2'd1, 1);
    issue(15'd9000, 10'd400, 0, 2'd1, 0);
    drain();
    chk_mode(1);
    issue(15'd100, 10'd600, 1, 2'd2, 1);
    drain();
    chk_mode(2);
    ch_en = 4'b1110;
    q_const = 4'hF;
    issue(15'd100, 10'd10, 1, 2'd0, 0);
    ch_en = 4'hF;
    issue(15'd5000, 10'd10, 1, 2'd3, 0);
    drain();
    chk_mode(3);
    use_const = 0;
    for (int n = 0; n < 1000; n++) begin
      v = ($urandom % 4) != 0;
      a = ADDR_W'($urandom);
      l = LINE_W'($urandom % 800);
      fs = ($urandom % 16) == 0;
      m = 2'($urandom);
      if ($urandom % 32 == 0) ch_en = NUM_CH'($urandom);
      req_valid = v;
      read_address = a;
      line_number = l;
      frame_start = fs;
      mode_in = m;
      if (v) push(model(a, l, fs ? m : cur_mode, ch_en));
      tick();
      if (fs) cur_mode = m;
    end
    req_valid = 0;
    frame_start = 0;
    drain();
    chk_mode(int'(cur_mode));
    ch_en = 4'hF;
    for (int n = 0; n < 3; n++) begin
      req_valid = 1;
      read_address = ADDR_W'(1000 + n * 7);
      line_number = 10'd5;
      push(model(read_address, line_number, cur_mode, ch_en));
      tick();
    end
    req_valid = 0;
    #2;
    rst_n = 0;
    sb0.delete();
    sb1.delete();
    cur_mode = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rst_q inst%0d", i), int'(Qo[i]), 0);
      chk($sformatf("async_rst_q_valid inst%0d", i), int'(Qv[i]), 0);
      chk($sformatf("async_rst_mem_addr inst%0d", i), int'(ma[i]), 0);
    end
    chk_mode(0);
    repeat (2) tick();
    rst_n = 1;
    repeat (10) tick();
    issue(15'd8200, 10'd3, 0, 2'd0, model(15'd8200, 10'd3, 2'd0, ch_en));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
